z80_wait_ctrl: RTL and testbench

- Wait-state sequencer for the Z80 bus on the CPLD.
- Detects the start of each CPU memory or I/O cycle and drives the Z80 WAIT_n line low for a programmable number of CPU T-states.
- Slow ROM/RAM2 accesses, fast RAM accesses and 16550 I/O each have their own wait count. Counts come from system-register bits.
- Runs in the 24 MHz domain and uses a CPU-clock falling-edge strobe from the clock divider. Also keeps a saturating count of inserted wait states for performance measurement.

---
 rtl/z80_wait_ctrl.sv | 163 ++++++++++++++++
 tb/tb_z80_wait_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_wait_ctrl.sv
// Z80 wait-state sequencer: detects each CPU memory/I/O cycle and holds
// WAIT_n low for a per-region number of CPU T-states.
//
// Ports:
//   clk            24 MHz master clock
//   reset_n        asynchronous active-low reset
//   cpu_clk_fall   one-clk strobe on each CPU clock falling edge
//   clk_bypass     CPU runs undivided; suppresses all waits
//   mreq_n, iorq_n, m1_n, rfsh_n   raw Z80 bus controls
//   slow_sel       current window is slow ROM/RAM2
//   uart_sel       I/O port decode hit on the 16550
//   cfg_*_waits    wait counts for slow mem, fast mem, 16550 I/O
//   stat_clr       synchronous clear of stat_waits
//   wait_n         registered Z80 WAIT output
//   busy           a bus cycle is being tracked
//   stat_waits     saturating count of inserted wait states
module z80_wait_ctrl #(
    parameter int CNT_W  = 3,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_clk_fall,
    input  logic              clk_bypass,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              rfsh_n,
    input  logic              slow_sel,
    input  logic              uart_sel,
    input  logic [CNT_W-1:0]  cfg_slow_waits,
    input  logic [CNT_W-1:0]  cfg_fast_waits,
    input  logic [CNT_W-1:0]  cfg_io_waits,
    input  logic              stat_clr,
    output logic              wait_n,
    output logic              busy,
    output logic [STAT_W-1:0] stat_waits
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nx;
    logic             wait_nx;
    logic             inc;

    logic mreq_r;
    logic iorq_r;
    logic m1_r;
    logic rfsh_r;
    logic cyc_d;

    logic             cyc_n;
    logic             refresh;
    logic             start;
    logic [CNT_W-1:0] n_sel;

    // Interrupt acknowledge (iorq low with m1 low) is masked here because
    // ~m1_n forces the I/O term high while mreq_n stays high.
    assign cyc_n   = mreq_r & (iorq_r | ~m1_r);
    assign refresh = ~mreq_r & ~rfsh_r;
    assign start   = (state_q == IDLE) & cyc_d & ~cyc_n & ~refresh;
    assign busy    = (state_q != IDLE);

    always_comb begin
        n_sel = '0;
        if (!clk_bypass) begin
            if (!mreq_r)
                n_sel = slow_sel ? cfg_slow_waits : cfg_fast_waits;
            else if (uart_sel)
                n_sel = cfg_io_waits;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mreq_r <= 1'b1;
            iorq_r <= 1'b1;
            m1_r   <= 1'b1;
            rfsh_r <= 1'b1;
            cyc_d  <= 1'b1;
        end else begin
            mreq_r <= mreq_n;
            iorq_r <= iorq_n;
            m1_r   <= m1_n;
            rfsh_r <= rfsh_n;
            cyc_d  <= cyc_n;
        end
    end

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        wait_nx  = wait_n;
        inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                wait_nx = 1'b1;
                if (start) begin
                    if (n_sel != '0) begin
                        cnt_nx   = n_sel;
                        wait_nx  = 1'b0;
                        state_nx = WAIT;
                    end else begin
                        state_nx = HOLD;
                    end
                end
            end
            WAIT: begin
                if (cyc_n) begin
                    // bus cycle aborted while stretched
                    wait_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt_q == '0) begin
                    wait_nx  = 1'b1;
                    state_nx = HOLD;
                end else if (cpu_clk_fall) begin
                    cnt_nx = cnt_q - CNT_W'(1);
                    inc    = 1'b1;
                end
            end
            HOLD: begin
                wait_nx = 1'b1;
                if (cyc_n)
                    state_nx = IDLE;
            end
            default: begin
                wait_nx  = 1'b1;
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_n  <= 1'b1;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            wait_n  <= wait_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stat_waits <= '0;
        else if (stat_clr)
            stat_waits <= '0;
        else if (inc && !(&stat_waits))
            stat_waits <= stat_waits + STAT_W'(1);
    end

endmodule

// File: tb/tb_z80_wait_ctrl.sv
// Testbench for z80_wait_ctrl: acts as a Z80 bus master, counts the CPU
// falling edges that see WAIT low and checks them against the wait rules.
module tb_z80_wait_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_clk_fall;
    logic        clk_bypass;
    logic        mreq_n;
    logic        iorq_n;
    logic        m1_n;
    logic        rfsh_n;
    logic        slow_sel;
    logic        uart_sel;
    logic [2:0]  cfg_slow;
    logic [2:0]  cfg_fast;
    logic [2:0]  cfg_io;
    logic        stat_clr;
    logic        wait_n;
    logic        busy;
    logic [15:0] stat16;
    logic        wait_n3;
    logic        busy3;
    logic [2:0]  stat3;

    z80_wait_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_clk_fall   (cpu_clk_fall),
        .clk_bypass     (clk_bypass),
        .mreq_n         (mreq_n),
        .iorq_n         (iorq_n),
        .m1_n           (m1_n),
        .rfsh_n         (rfsh_n),
        .slow_sel       (slow_sel),
        .uart_sel       (uart_sel),
        .cfg_slow_waits (cfg_slow),
        .cfg_fast_waits (cfg_fast),
        .cfg_io_waits   (cfg_io),
        .stat_clr       (stat_clr),
        .wait_n         (wait_n),
        .busy           (busy),
        .stat_waits     (stat16)
    );

    // narrow statistics copy so saturation is reachable in a short run
    z80_wait_ctrl #(.CNT_W(3), .STAT_W(3)) dut_sat (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_clk_fall   (cpu_clk_fall),
        .clk_bypass     (clk_bypass),
        .mreq_n         (mreq_n),
        .iorq_n         (iorq_n),
        .m1_n           (m1_n),
        .rfsh_n         (rfsh_n),
        .slow_sel       (slow_sel),
        .uart_sel       (uart_sel),
        .cfg_slow_waits (cfg_slow),
        .cfg_fast_waits (cfg_fast),
        .cfg_io_waits   (cfg_io),
        .stat_clr       (stat_clr),
        .wait_n         (wait_n3),
        .busy           (busy3),
        .stat_waits     (stat3)
    );

    always #5 clk = ~clk;

    localparam int K_MEM  = 0;
    localparam int K_IO   = 1;
    localparam int K_RFSH = 2;
    localparam int K_INTA = 3;

    typedef struct {
        int kind;
        bit slow;
        bit uart;
        bit byp;
        int cs;
        int cf;
        int ci;
        int per;
        int off;
        int exp;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   per    = 4;
    int   div    = 0;
    int   total  = 0;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        div = (div + 1 >= per) ? 0 : div + 1;
        cpu_clk_fall = (div == 0);
    endtask

    function automatic int exp_n(int kind, bit slow, bit uart, bit byp,
                                 int cs, int cf, int ci);
        if (kind == K_RFSH || kind == K_INTA) return 0;
        if (byp) return 0;
        if (kind == K_MEM) return slow ? cs : cf;
        return uart ? ci : 0;
    endfunction

    task automatic check_stats(string tag);
        check({tag, "_stat16"}, int'(stat16), total > 65535 ? 65535 : total);
        check({tag, "_stat3"}, int'(stat3), total > 7 ? 7 : total);
    endtask

    task automatic begin_cycle(int kind, bit slow, bit uart, int off,
                               output bit skip);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_clk_fall) break;
        end
        repeat (off) tick();
        skip = (off == per - 1);
        slow_sel = slow;
        uart_sel = uart;
        case (kind)
            K_MEM:  mreq_n = 1'b0;
            K_IO:   iorq_n = 1'b0;
            K_RFSH: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
            default: begin iorq_n = 1'b0; m1_n = 1'b0; end
        endcase
    endtask

    task automatic count_lows(int k, string tag);
        int got = 0;
        for (int t = 0; t < 200 && got < k; t++) begin
            tick();
            if (cpu_clk_fall && !wait_n) got++;
        end
        check({tag, "_partial_lows"}, got, k);
    endtask

    task automatic count_cycle(bit skip_in, int mid, string tag,
                               output int lows, output bit busy_seen);
        bit skip = skip_in;
        bit done = 0;
        lows = 0;
        busy_seen = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            tick();
            if (busy) busy_seen = 1;
            if (mid >= 0 && t == 2) cfg_slow = 3'(mid);
            if (cpu_clk_fall) begin
                if (skip) skip = 0;
                else if (!wait_n) lows++;
                else done = 1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got wait_n low expected release", tag);
        end
    endtask

    task automatic end_cycle(string tag);
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        rfsh_n = 1'b1;
        repeat (3) tick();
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_wait"}, int'(wait_n), 1);
    endtask

    task automatic run_vec(vec_t v, int mid, string tag);
        bit skip;
        int lows;
        bit bs;
        per = v.per;
        clk_bypass = v.byp;
        cfg_slow = 3'(v.cs);
        cfg_fast = 3'(v.cf);
        cfg_io   = 3'(v.ci);
        begin_cycle(v.kind, v.slow, v.uart, v.off, skip);
        count_cycle(skip, mid, tag, lows, bs);
        check({tag, "_lows"}, lows, v.exp);
        check({tag, "_busy"}, int'(bs),
              (v.kind == K_MEM || v.kind == K_IO) ? 1 : 0);
        end_cycle(tag);
        total += v.exp;
        check_stats(tag);
        clk_bypass = 1'b0;
    endtask

    initial begin
        vec_t v;
        bit   skip;
        int   lows;
        bit   bs;

        reset_n = 1'b0;
        cpu_clk_fall = 1'b0;
        clk_bypass = 1'b0;
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        m1_n = 1'b1;
        rfsh_n = 1'b1;
        slow_sel = 1'b0;
        uart_sel = 1'b0;
        cfg_slow = 3'd0;
        cfg_fast = 3'd0;
        cfg_io = 3'd0;
        stat_clr = 1'b0;

        //            kind    sl uart byp cs cf ci per off exp
        tbl.push_back('{K_MEM,  1, 0, 0, 2, 0, 0, 4, 0, 2});
        tbl.push_back('{K_MEM,  0, 0, 0, 7, 0, 0, 4, 0, 0});
        tbl.push_back('{K_MEM,  1, 0, 0, 7, 0, 0, 4, 1, 7});
        tbl.push_back('{K_IO,   0, 1, 0, 0, 0, 3, 4, 0, 3});
        tbl.push_back('{K_IO,   0, 0, 0, 0, 0, 3, 4, 0, 0});
        tbl.push_back('{K_INTA, 0, 1, 0, 5, 5, 5, 4, 0, 0});
        tbl.push_back('{K_RFSH, 1, 0, 0, 5, 5, 5, 4, 0, 0});
        tbl.push_back('{K_MEM,  1, 0, 1, 5, 0, 0, 4, 0, 0});
        tbl.push_back('{K_MEM,  1, 0, 0, 3, 0, 0, 2, 1, 3});
        tbl.push_back('{K_MEM,  0, 0, 0, 0, 4, 0, 4, 3, 4});
        tbl.push_back('{K_IO,   0, 1, 0, 0, 0, 7, 3, 2, 7});
        tbl.push_back('{K_MEM,  1, 0, 0, 1, 0, 0, 6, 5, 1});

        repeat (3) tick();
        check("rst_wait", int'(wait_n), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_stat", int'(stat16), 0);
        reset_n = 1'b1;
        repeat (3) tick();

        foreach (tbl[i]) run_vec(tbl[i], -1, $sformatf("vec%0d", i));

        // config change mid-cycle applies to the following cycle
        v = '{K_MEM, 1, 0, 0, 2, 0, 0, 4, 0, 2};
        run_vec(v, 4, "midcfg_a");
        v = '{K_MEM, 1, 0, 0, 4, 0, 0, 4, 0, 4};
        run_vec(v, -1, "midcfg_b");

        // abort while waits are being inserted
        per = 4;
        cfg_slow = 3'd5;
        begin_cycle(K_MEM, 1, 0, 0, skip);
        count_lows(2, "abort");
        mreq_n = 1'b1;
        tick();
        tick();
        check("abort_wait", int'(wait_n), 1);
        check("abort_busy", int'(busy), 0);
        total += 2;
        check_stats("abort");
        repeat (4) tick();

        // stat_clr coincident with a counted strobe
        cfg_slow = 3'd3;
        begin_cycle(K_MEM, 1, 0, 0, skip);
        count_lows(1, "clr");
        count_lows(1, "clr");
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        total = 0;
        check_stats("clr_now");
        count_cycle(1'b0, -1, "clr", lows, bs);
        check("clr_rest_lows", lows, 1);
        end_cycle("clr");
        total += 1;
        check_stats("clr_end");

        // asynchronous reset in the middle of a stretched cycle
        cfg_slow = 3'd5;
        begin_cycle(K_MEM, 1, 0, 0, skip);
        count_lows(2, "areset");
        tick();
        reset_n = 1'b0;
        #1;
        check("areset_wait", int'(wait_n), 1);
        check("areset_busy", int'(busy), 0);
        check("areset_stat", int'(stat16), 0);
        mreq_n = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        total = 0;
        repeat (3) tick();
        run_vec(tbl[0], -1, "post_rst");

        // randomized cycles against the rule-level model
        for (int r = 0; r < 40; r++) begin
            v.kind = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 1)
                                                : $urandom_range(2, 3);
            v.slow = 1'($urandom);
            v.uart = 1'($urandom);
            v.byp  = ($urandom_range(0, 7) == 0);
            v.cs   = $urandom_range(0, 7);
            v.cf   = $urandom_range(0, 7);
            v.ci   = $urandom_range(0, 7);
            v.per  = $urandom_range(2, 6);
            v.off  = $urandom_range(0, v.per - 1);
            v.exp  = exp_n(v.kind, v.slow, v.uart, v.byp,
                           v.cs, v.cf, v.ci);
            run_vec(v, -1, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
